// File: rtl/wheel_steer_ctrl.sv
// wheel_steer_ctrl: turns wheel-decoder detent pulses into lane-change
// requests for the game logic, tracks the current lane and runs the encoder
// re-zeroing (calibration) sequence.
//
// Handshake: move_req rises when a move is pending and stays high, with
// move_dir stable, until the first clock edge that samples move_ack=1. That
// edge commits the lane change, and move_req drops in the following cycle.
// move_ack is ignored whenever no request is pending.
module wheel_steer_ctrl #(
  parameter int STEPS_PER_MOVE  = 4,
  parameter int COOLDOWN_CYCLES = 8,
  parameter int NUM_LANES       = 5,
  parameter int CALIB_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cw_pulse,
  input  logic       ccw_pulse,
  input  logic       enable,
  input  logic       calib,
  input  logic       move_ack,
  output logic       move_req,
  output logic       move_dir,
  output logic [2:0] lane,
  output logic       limit_hit,
  output logic       enc_clear,
  output logic       busy,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_COOLDOWN = 2'd2,
    S_CALIB    = 2'd3
  } state_t;

  localparam int CNT_W = 16;
  localparam logic [2:0] CENTER    = 3'((NUM_LANES - 1) / 2);
  localparam logic [2:0] LAST_LANE = 3'(NUM_LANES - 1);
  localparam logic signed [3:0] ACC_POS = 4'(STEPS_PER_MOVE);
  localparam logic signed [3:0] ACC_NEG = 4'(-STEPS_PER_MOVE);

  state_t             r_state;
  logic signed [3:0]  r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_lane;
  logic               r_move_req;
  logic               r_move_dir;
  logic               r_limit_hit;
  logic               r_enc_clear;
  logic signed [3:0]  w_acc_next;

  // Accumulator value if this cycle's detent pulses were applied;
  // simultaneous CW and CCW pulses cancel out.
  always_comb begin
    w_acc_next = r_acc;
    if (cw_pulse && !ccw_pulse) begin
      w_acc_next = r_acc + 4'sd1;
    end else if (ccw_pulse && !cw_pulse) begin
      w_acc_next = r_acc - 4'sd1;
    end
  end

  // Sequencer: accumulation, request handshake, cooldown and calibration.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_acc       <= 4'sd0;
      r_cnt       <= '0;
      r_lane      <= CENTER;
      r_move_req  <= 1'b0;
      r_move_dir  <= 1'b0;
      r_limit_hit <= 1'b0;
      r_enc_clear <= 1'b0;
    end else begin
      r_limit_hit <= 1'b0;
      if (calib) begin
        // Calibration overrides everything; a held calib keeps reloading
        // the count so the final CALIB_CYCLES run starts when it drops.
        r_state     <= S_CALIB;
        r_cnt       <= CNT_W'(CALIB_CYCLES);
        r_enc_clear <= 1'b1;
        r_move_req  <= 1'b0;
        r_acc       <= 4'sd0;
        r_lane      <= CENTER;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (enable) begin
              if (w_acc_next == ACC_POS) begin
                r_acc <= 4'sd0;
                if (r_lane < LAST_LANE) begin
                  r_state    <= S_REQ;
                  r_move_req <= 1'b1;
                  r_move_dir <= 1'b1;
                end else begin
                  r_limit_hit <= 1'b1;
                end
              end else if (w_acc_next == ACC_NEG) begin
                r_acc <= 4'sd0;
                if (r_lane > 3'd0) begin
                  r_state    <= S_REQ;
                  r_move_req <= 1'b1;
                  r_move_dir <= 1'b0;
                end else begin
                  r_limit_hit <= 1'b1;
                end
              end else begin
                r_acc <= w_acc_next;
              end
            end
          end
          S_REQ: begin
            if (move_ack) begin
              r_move_req <= 1'b0;
              r_lane     <= r_move_dir ? (r_lane + 3'd1) : (r_lane - 3'd1);
              r_state    <= S_COOLDOWN;
              r_cnt      <= CNT_W'(COOLDOWN_CYCLES);
            end
          end
          S_COOLDOWN: begin
            if (r_cnt <= CNT_W'(1)) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          S_CALIB: begin
            if (r_cnt <= CNT_W'(1)) begin
              r_state     <= S_IDLE;
              r_enc_clear <= 1'b0;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign move_req  = r_move_req;
  assign move_dir  = r_move_dir;
  assign lane      = r_lane;
  assign limit_hit = r_limit_hit;
  assign enc_clear = r_enc_clear;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_wheel_steer_ctrl.sv
// tb_wheel_steer_ctrl: directed scenarios followed by randomized traffic,
// all outputs compared every cycle against a behavioural model that tracks
// "pending move", "cooldown cycles left" and "calibration cycles left".
module tb_wheel_steer_ctrl;

  localparam int STEPS  = 4;
  localparam int COOL   = 8;
  localparam int NL     = 5;
  localparam int CALIBN = 4;
  localparam int CENTER = (NL - 1) / 2;

  // clock / reset
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst = 1'b1;
  logic cw = 1'b0, ccw = 1'b0, en = 1'b0, cal = 1'b0, ack = 1'b0;
  logic       move_req, move_dir, limit_hit, enc_clear, busy;
  logic [2:0] lane;
  logic [1:0] dbg_state;

  wheel_steer_ctrl #(
    .STEPS_PER_MOVE (STEPS),
    .COOLDOWN_CYCLES(COOL),
    .NUM_LANES      (NL),
    .CALIB_CYCLES   (CALIBN)
  ) dut (
    .clk      (clk),
    .reset    (rst),
    .cw_pulse (cw),
    .ccw_pulse(ccw),
    .enable   (en),
    .calib    (cal),
    .move_ack (ack),
    .move_req (move_req),
    .move_dir (move_dir),
    .lane     (lane),
    .limit_hit(limit_hit),
    .enc_clear(enc_clear),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // behavioural reference model
  int m_acc = 0, m_lane = CENTER, m_cool = 0, m_cal = 0;
  bit m_pending = 0, m_dir = 0, m_limit = 0;

  task automatic model_step();
    int n;
    if (rst) begin
      m_acc = 0; m_lane = CENTER; m_cool = 0; m_cal = 0;
      m_pending = 0; m_dir = 0; m_limit = 0;
    end else begin
      m_limit = 0;
      if (cal) begin
        m_cal = CALIBN; m_pending = 0; m_cool = 0; m_acc = 0; m_lane = CENTER;
      end else if (m_cal > 0) begin
        m_cal--;
      end else if (m_pending) begin
        if (ack) begin
          m_pending = 0;
          m_lane    = m_dir ? m_lane + 1 : m_lane - 1;
          m_cool    = COOL;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (en) begin
        n = m_acc + (cw ? 1 : 0) - (ccw ? 1 : 0);
        if (n == STEPS || n == -STEPS) begin
          m_acc = 0;
          if (n == STEPS && m_lane < NL - 1) begin
            m_pending = 1; m_dir = 1;
          end else if (n == -STEPS && m_lane > 0) begin
            m_pending = 1; m_dir = 0;
          end else begin
            m_limit = 1;
          end
        end else begin
          m_acc = n;
        end
      end
    end
  endtask

  task automatic compare();
    chk("move_req", move_req, m_pending);
    if (m_pending) chk("move_dir", move_dir, m_dir);
    chk("lane", lane, m_lane);
    chk("limit_hit", limit_hit, m_limit);
    chk("enc_clear", enc_clear, (m_cal > 0));
    chk("busy", busy, (m_pending || m_cool > 0 || m_cal > 0));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input logic c, input logic cc, input logic e, input logic ca, input logic a);
    cw = c; ccw = cc; en = e; cal = ca; ack = a;
    tick();
  endtask

  task automatic pulses(input logic dir, input int n);
    for (int i = 0; i < n; i++) drive(dir, !dir, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_move(input logic dir);
    pulses(dir, STEPS);
    drive(0, 0, 1, 0, 1);
    for (int i = 0; i < COOL; i++) drive(0, 0, 1, 0, 0);
  endtask

  int cal_hold = 0;

  initial begin
    // reset
    rst = 1'b1;
    tick(); tick();
    chk("rst_move_req", move_req, 0);
    chk("rst_lane", lane, CENTER);
    chk("rst_busy", busy, 0);
    chk("rst_enc_clear", enc_clear, 0);
    chk("rst_limit", limit_hit, 0);
    rst = 1'b0;

    // 1: four CW detents -> request right, ack, cooldown of 8
    pulses(1, STEPS);
    chk("t1_req", move_req, 1);
    chk("t1_dir", move_dir, 1);
    drive(0, 0, 1, 0, 1);
    chk("t1_lane", lane, 3);
    chk("t1_req_drop", move_req, 0);
    for (int i = 0; i < COOL - 1; i++) drive(0, 0, 1, 0, 0);
    chk("t1_busy_last", busy, 1);
    drive(0, 0, 1, 0, 0);
    chk("t1_idle", busy, 0);

    // 2: mixed directions and cancelling pulses
    pulses(1, 3);
    pulses(0, 1);
    pulses(1, 1);
    chk("t2_no_req_yet", move_req, 0);
    pulses(1, 1);
    chk("t2_req", move_req, 1);
    drive(0, 0, 1, 0, 1);
    for (int i = 0; i < COOL; i++) drive(0, 0, 1, 0, 0);
    chk("t2_lane", lane, 4);
    for (int i = 0; i < 3; i++) begin
      pulses(1, 1);
      pulses(0, 1);
    end
    for (int i = 0; i < 6; i++) drive(1, 1, 1, 0, 0);
    chk("t2_cancel", move_req, 0);

    // 3: threshold at the right edge, then at the left edge
    pulses(1, STEPS);
    chk("t3_limit_r", limit_hit, 1);
    chk("t3_lane_r", lane, 4);
    drive(0, 0, 1, 0, 0);
    chk("t3_limit_pulse", limit_hit, 0);
    for (int i = 0; i < 4; i++) do_move(0);
    chk("t3_lane0", lane, 0);
    pulses(0, STEPS);
    chk("t3_limit_l", limit_hit, 1);
    chk("t3_no_req", move_req, 0);

    // 4: held request ignores pulses and enable=0
    pulses(1, STEPS);
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      chk("t4_hold_req", move_req, 1);
      chk("t4_hold_dir", move_dir, 1);
    end
    drive(0, 0, 0, 0, 1);
    chk("t4_lane", lane, 1);
    for (int i = 0; i < COOL; i++) drive(0, 0, 1, 0, 0);

    // 5: calibration abandons a pending request from lane 3
    do_move(1);
    do_move(1);
    pulses(1, STEPS);
    chk("t5_req", move_req, 1);
    drive(0, 0, 1, 1, 0);
    chk("t5_req_drop", move_req, 0);
    chk("t5_clear", enc_clear, 1);
    chk("t5_center", lane, CENTER);
    for (int i = 0; i < CALIBN - 1; i++) drive(1, 0, 1, 0, 1);
    chk("t5_clear_last", enc_clear, 1);
    drive(0, 0, 1, 0, 0);
    chk("t5_clear_off", enc_clear, 0);
    chk("t5_idle", busy, 0);

    // 6: pulses during cooldown, then reset mid-cooldown
    pulses(1, STEPS);
    drive(0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 1);
    rst = 1'b1;
    drive(1, 0, 1, 0, 0);
    chk("t6_rst_lane", lane, CENTER);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_req", move_req, 0);
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      cw  = ($urandom_range(0, 2) == 0);
      ccw = ($urandom_range(0, 3) == 0);
      en  = ($urandom_range(0, 7) != 0);
      ack = ($urandom_range(0, 2) == 0);
      if (cal_hold > 0) begin
        cal = 1'b1;
        cal_hold--;
      end else if ($urandom_range(0, 79) == 0) begin
        cal = 1'b1;
        cal_hold = $urandom_range(0, 5);
      end else begin
        cal = 1'b0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
